// File: rtl/min_readout.sv
// Minimum-result readout engine: issues credit-limited reads to the ordering or distance
// result memory, buffers responses and streams them to the host with valid/ready.
// Optional distance path is built only when MIN_READOUT_DIST_EN is defined.
module min_readout #(
  parameter int FIFO_DEPTH       = 4,
  parameter int CITY_DIV_LOG     = 3,
  parameter int SITER_LOG        = 4,
  parameter int REPLICA_DATA_BIT = 16,
  parameter int TOTAL_DATA_W     = 24,
  parameter int OUT_W            = (REPLICA_DATA_BIT > TOTAL_DATA_W) ? REPLICA_DATA_BIT
                                                                     : TOTAL_DATA_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start_ord,
  input  logic                        start_dist,
  input  logic [SITER_LOG:0]          dist_count,
  input  logic                        opt_run,
  output logic                        min_ord_read,
  input  logic                        ordering_min_valid,
  input  logic [REPLICA_DATA_BIT-1:0] ordering_min_data,
  output logic                        min_distance_read,
  input  logic                        distance_min_valid,
  input  logic [TOTAL_DATA_W-1:0]     distance_min_data,
  output logic                        out_valid,
  output logic [OUT_W-1:0]            out_data,
  output logic                        out_last,
  input  logic                        out_ready,
  output logic                        busy,
  output logic                        abort
);

  localparam int CNT_W  = ((CITY_DIV_LOG > SITER_LOG) ? CITY_DIV_LOG : SITER_LOG) + 1;
  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int FCNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ORD_RD  = 2'd1,
`ifdef MIN_READOUT_DIST_EN
    DIST_RD = 2'd3,
`endif
    DRAIN   = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    target, issued, pushed;
  logic                inflight;
  logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
  logic [FCNT_W-1:0]   fifo_count;
  logic [FCNT_W:0]     occupancy;
  logic [OUT_W:0]      mem [FIFO_DEPTH];
  logic [OUT_W:0]      head;

  logic                reading, credit_ok, rd_strobe, last_issue;
  logic                resp_valid, push, pop, last_pop, abort_now, push_last;
  logic [OUT_W-1:0]    resp_data;

`ifdef MIN_READOUT_DIST_EN
  logic                is_dist;

  assign reading           = (state == ORD_RD) || (state == DIST_RD);
  assign resp_valid        = is_dist ? distance_min_valid : ordering_min_valid;
  assign resp_data         = is_dist ? OUT_W'(distance_min_data) : OUT_W'(ordering_min_data);
  assign min_distance_read = rd_strobe && (state == DIST_RD);
`else
  logic                unused_dist;

  assign reading           = (state == ORD_RD);
  assign resp_valid        = ordering_min_valid;
  assign resp_data         = OUT_W'(ordering_min_data);
  assign min_distance_read = 1'b0;
  assign unused_dist       = ^{start_dist, dist_count, distance_min_valid, distance_min_data};
`endif

  // A word may be requested only if the FIFO can hold it plus the response still in flight.
  assign occupancy    = {1'b0, fifo_count} + {{FCNT_W{1'b0}}, inflight};
  assign credit_ok    = occupancy < (FCNT_W+1)'(FIFO_DEPTH);
  assign rd_strobe    = reading && (issued < target) && !opt_run && credit_ok;
  assign last_issue   = rd_strobe && (issued == target - CNT_W'(1));
  assign min_ord_read = rd_strobe && (state == ORD_RD);

  assign abort_now = opt_run && (state != IDLE);
  assign push      = resp_valid && (state != IDLE) && !abort_now;
  assign push_last = (pushed == target - CNT_W'(1));
  assign head      = mem[rd_ptr];
  assign out_valid = (fifo_count != '0);
  assign out_data  = out_valid ? head[OUT_W-1:0] : '0;
  assign out_last  = out_valid && head[OUT_W];
  assign pop       = out_valid && out_ready;
  assign last_pop  = pop && head[OUT_W];
  assign busy      = (state != IDLE);

  always_comb begin
    // NOTE: assign every combinational output a default first so no path infers a latch.
    state_next = state;
    case (state)
      IDLE: begin
        if (start_ord) state_next = ORD_RD;
`ifdef MIN_READOUT_DIST_EN
        else if (start_dist) state_next = DIST_RD;
`endif
      end
      ORD_RD:  if (last_issue) state_next = DRAIN;
`ifdef MIN_READOUT_DIST_EN
      DIST_RD: if (last_issue) state_next = DRAIN;
`endif
      DRAIN:   if (last_pop) state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort_now) state_next = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      target   <= '0;
      issued   <= '0;
      pushed   <= '0;
      inflight <= 1'b0;
      abort    <= 1'b0;
`ifdef MIN_READOUT_DIST_EN
      is_dist  <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      inflight <= rd_strobe;
      abort    <= abort_now;
      if (state == IDLE && state_next == ORD_RD) begin
        target <= CNT_W'(1) << CITY_DIV_LOG;
        issued <= '0;
        pushed <= '0;
`ifdef MIN_READOUT_DIST_EN
        is_dist <= 1'b0;
      end else if (state == IDLE && state_next == DIST_RD) begin
        target  <= (dist_count == '0) ? (CNT_W'(1) << SITER_LOG) : CNT_W'(dist_count);
        issued  <= '0;
        pushed  <= '0;
        is_dist <= 1'b1;
`endif
      end else begin
        issued <= issued + CNT_W'(rd_strobe);
        pushed <= pushed + CNT_W'(push);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (abort_now) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCNT_W'(1);
        2'b01:   fifo_count <= fifo_count - FCNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // NOTE: storage is not reset; out_data/out_last are masked by out_valid so stale words never leak.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_last, resp_data};
  end

endmodule

// File: doc/min_readout.md
MIN_READOUT -- requirements
Module: min_readout

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of 2, at least 2).
REQ-002 SHALL have parameter OUT_W, default max(replica_data_bit, $bits(total_data_t)), output word width.
REQ-003 SHALL have ports: clk input 1, the single clock; reset input 1, asynchronous active-low reset.
REQ-004 SHALL have ports: start_ord input 1, pulse that requests an ordering readout; start_dist input 1, pulse that requests a distance readout.
REQ-005 SHALL have port dist_count input siter_log+1, number of distance entries to read; 0 means 2**siter_log.
REQ-006 SHALL have port opt_run input 1, annealing run active, which aborts any readout.
REQ-007 SHALL have ports min_ord_read output 1 and ordering_min_valid input 1 (1-cycle response), plus ordering_min_data input replica_data_bit.
REQ-008 SHALL have ports min_distance_read output 1 and distance_min_valid input 1 (1-cycle response), plus distance_min_data input $bits(total_data_t).
REQ-009 SHALL have ports out_valid output 1, out_data output OUT_W, out_last output 1 and out_ready input 1, forming the host stream.
REQ-010 SHALL have ports busy output 1 (readout in progress) and abort output 1 (single-cycle pulse on abort).

Function
REQ-011 SHALL implement FSM states IDLE, ORD_RD, DIST_RD and DRAIN.
REQ-012 SHALL go IDLE->ORD_RD on start_ord; IDLE->DIST_RD on start_dist; start_ord wins if both are high in the same cycle; starts outside IDLE are ignored.
REQ-013 SHALL set target count to 2**city_div_log words in ORD_RD and to dist_count (0 -> 2**siter_log) in DIST_RD, with the issue counter cleared on entry.
REQ-014 SHALL assert the read strobe for the current state (min_ord_read or min_distance_read) for one cycle per word only when issued < target, opt_run=0 and fifo_count + inflight < FIFO_DEPTH.
REQ-015 SHALL treat inflight as the read strobe of the previous cycle (at most 1); the credit check SHALL guarantee the FIFO never overflows.
REQ-016 SHALL push the response data, zero-extended to OUT_W, into the FIFO on each incoming *_min_valid; valid inputs outside a readout SHALL be ignored.
REQ-017 SHALL move ORD_RD/DIST_RD->DRAIN when the last read is issued, and DRAIN->IDLE once the last word has been handshaken (out_valid & out_ready).
REQ-018 SHALL assert out_last with the final word of each readout only.
REQ-019 SHALL follow valid/ready rules: out_data and out_last stable while out_valid=1 & out_ready=0; out_valid not dropped without a handshake except on abort.
REQ-020 SHALL allow a FIFO push and pop in the same cycle when full, leaving the count unchanged; pop on empty SHALL never occur.
REQ-021 SHALL, on opt_run=1 while busy: go to IDLE next cycle, flush the FIFO, drop out_valid, pulse abort for 1 cycle, and discard any late response.
REQ-022 SHALL assert busy whenever state != IDLE.
REQ-023 SHALL deliver the first out_valid 2 cycles after start when out_ready=1 (strobe, then response, then FIFO register); sustained throughput SHALL be 1 word/cycle.

Reset
REQ-024 SHALL apply asynchronous reset (reset=0): state IDLE, counters 0, FIFO empty; out_valid, out_last, min_ord_read, min_distance_read, busy and abort all 0; out_data 0.
REQ-025 SHALL require reset release to be synchronous to clk; the first start is accepted on the first cycle after release.

Configuration
REQ-026 SHALL, with macro MIN_READOUT_DIST_EN defined, build the DIST_RD path as specified.
REQ-027 SHALL, without MIN_READOUT_DIST_EN, omit the DIST_RD state and distance logic, ignore start_dist, tie min_distance_read to 0, and leave dist_count and distance_min_* unused.

Verification (city_div_log=3, siter_log=4, FIFO_DEPTH=4)
REQ-028 SHALL cover: start_ord, out_ready=1 -> 8 strobes on consecutive cycles, 8 words in order, out_last on word 8, busy drops after it.
REQ-029 SHALL cover: start_dist with dist_count=5, out_ready=0 -> exactly 4 strobes, then stall; raise out_ready -> 5 words total, out_last on word 5.
REQ-030 SHALL cover: dist_count=0 -> 16 distance words, out_last on word 16.
REQ-031 SHALL cover: opt_run=1 at word 3 of an ordering readout -> abort pulse, out_valid=0 next cycle, FIFO empty, a new start_ord yields 8 clean words.
REQ-032 SHALL cover: start_ord and start_dist in the same cycle -> ordering readout only; start_dist while busy -> ignored.
REQ-033 SHALL cover: reset asserted mid-readout -> all outputs 0 asynchronously, state IDLE after release.
